// File: rtl/uart_word_tx.sv
// uart_word_tx: sends a DATA_W-bit word as DATA_W/8 UART frames, least-significant byte first.
// Each frame is a start bit, 8 data bits (LSB first), an optional parity bit and 1 or 2 stop bits.
// All outputs are registered: they are computed from the next-state values.
module uart_word_tx #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              TxD_start,
  input  logic [DATA_W-1:0] dataIn,
  output logic              busy,
  output logic              dataOver,
  output logic              dataOut
);

  localparam int unsigned NumBytes = DATA_W / 8;
  localparam int unsigned TickW    = $clog2(STOP_BITS * CLKS_PER_BIT + 1);
  localparam int unsigned ByteW    = $clog2(NumBytes + 1);

  localparam logic [TickW-1:0] BitEnd   = TickW'(CLKS_PER_BIT - 1);
  localparam logic [TickW-1:0] StopEnd  = TickW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [ByteW-1:0] LastByte = ByteW'(NumBytes - 1);
  localparam logic             OddBit   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StDone
  } state_e;

  state_e            r_state, w_state_nxt;
  logic [TickW-1:0]  r_tick, w_tick_nxt;
  logic [2:0]        r_bit, w_bit_nxt;
  logic [ByteW-1:0]  r_byte, w_byte_nxt;
  // Current byte always sits in the low 8 bits; it shifts down by a byte per frame.
  logic [DATA_W-1:0] r_shift, w_shift_nxt;

  logic r_busy, r_over, r_line;
  logic w_busy_nxt, w_over_nxt, w_line_nxt;

  // State, counters, shift register and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_tick  <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_shift <= '0;
      r_busy  <= 1'b0;
      r_over  <= 1'b0;
      r_line  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_bit   <= w_bit_nxt;
      r_byte  <= w_byte_nxt;
      r_shift <= w_shift_nxt;
      r_busy  <= w_busy_nxt;
      r_over  <= w_over_nxt;
      r_line  <= w_line_nxt;
    end
  end

  // Next-state logic: tick counter paces each bit; bit and byte counters walk the frame and word.
  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_bit_nxt   = r_bit;
    w_byte_nxt  = r_byte;
    w_shift_nxt = r_shift;
    unique case (r_state)
      StIdle: begin
        if (TxD_start) begin
          w_shift_nxt = dataIn;
          w_byte_nxt  = '0;
          w_bit_nxt   = '0;
          w_tick_nxt  = '0;
          w_state_nxt = StStart;
        end
      end
      StStart: begin
        if (r_tick == BitEnd) begin
          w_tick_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = StData;
        end else begin
          w_tick_nxt = r_tick + 1'b1;
        end
      end
      StData: begin
        if (r_tick == BitEnd) begin
          w_tick_nxt = '0;
          if (r_bit == 3'd7) begin
            w_state_nxt = (PARITY_EN != 0) ? StParity : StStop;
          end else begin
            w_bit_nxt = r_bit + 1'b1;
          end
        end else begin
          w_tick_nxt = r_tick + 1'b1;
        end
      end
      StParity: begin
        if (r_tick == BitEnd) begin
          w_tick_nxt  = '0;
          w_state_nxt = StStop;
        end else begin
          w_tick_nxt = r_tick + 1'b1;
        end
      end
      StStop: begin
        if (r_tick == StopEnd) begin
          w_tick_nxt = '0;
          if (r_byte < LastByte) begin
            w_byte_nxt  = r_byte + 1'b1;
            w_shift_nxt = r_shift >> 8;
            w_state_nxt = StStart;
          end else begin
            w_state_nxt = StDone;
          end
        end else begin
          w_tick_nxt = r_tick + 1'b1;
        end
      end
      StDone: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // Output values for the state being entered, so the outputs come straight from flops.
  always_comb begin
    w_busy_nxt = 1'b0;
    w_over_nxt = 1'b0;
    w_line_nxt = 1'b1;
    unique case (w_state_nxt)
      StStart: begin
        w_busy_nxt = 1'b1;
        w_line_nxt = 1'b0;
      end
      StData: begin
        w_busy_nxt = 1'b1;
        w_line_nxt = w_shift_nxt[w_bit_nxt];
      end
      StParity: begin
        w_busy_nxt = 1'b1;
        w_line_nxt = (^w_shift_nxt[7:0]) ^ OddBit;
      end
      StStop: begin
        w_busy_nxt = 1'b1;
      end
      StDone: begin
        w_over_nxt = 1'b1;
      end
      default: begin
        w_line_nxt = 1'b1;
      end
    endcase
  end

  assign busy     = r_busy;
  assign dataOver = r_over;
  assign dataOut  = r_line;

endmodule
